// File: rtl/prng_pkg.sv
// Shared constants for prng_gen: LFSR tap masks per width and active-low 7-segment codes.
// The hex output itself is only built when PRNG_HEX_EN is defined.
package prng_pkg;

  // Tap masks: bit i set means state[i] feeds the XNOR feedback.
  localparam logic [31:0] TAP_MASK_4  = 32'h0000_000C;  // taps 3,2
  localparam logic [31:0] TAP_MASK_8  = 32'h0000_00B8;  // taps 7,5,4,3
  localparam logic [31:0] TAP_MASK_16 = 32'h0000_D008;  // taps 15,14,12,3
  localparam logic [31:0] TAP_MASK_32 = 32'h8020_0003;  // taps 31,21,1,0

  function automatic logic [31:0] tap_mask(input int width);
    logic [31:0] m;
    m = '0;
    case (width)
      4:       m = TAP_MASK_4;
      8:       m = TAP_MASK_8;
      16:      m = TAP_MASK_16;
      32:      m = TAP_MASK_32;
      default: m = '0;
    endcase
    return m;
  endfunction

  typedef logic [6:0] seg_t;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

  function automatic seg_t seg_code(input logic [3:0] nibble);
    seg_t s;
    s = SEG_0;
    case (nibble)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/prng_lfsr_core.sv
// Left-shifting XNOR LFSR with synchronous seed load; the all-ones lockup seed loads as zero.
module prng_lfsr_core
  import prng_pkg::*;
#(
  parameter int            W    = 8,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic         CLK,
  input  logic         EN,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(tap_mask(W));

  logic         fb;
  logic [W-1:0] load_safe;

  // XNOR feedback: all-zero is a legal state, all-ones is the stuck state.
  assign fb        = ~^(state & TAPS);
  assign load_safe = (&load_val) ? '0 : load_val;

  always_ff @(posedge CLK) begin
    if (!EN) begin
      state <= INIT;
    end else if (load) begin
      state <= load_safe;
    end else if (step) begin
      state <= {state[W-2:0], fb};
    end
  end

endmodule

// File: rtl/prng_gen.sv
// Divider-paced PRNG: data LFSR bit pairs selected by a control LFSR, with valid/ready output.
// Define PRNG_HEX_EN to add the registered active-low 7-segment hex port.
module prng_gen
  import prng_pkg::*;
#(
  parameter int                  OUT_W     = 8,
  parameter int unsigned         DIV       = 50_000_000,
  parameter logic [2*OUT_W-1:0]  SEED_DATA = '0,
  parameter logic [OUT_W-1:0]    SEED_CTRL = '0
) (
  input  logic                 CLK,
  input  logic                 EN,
  input  logic                 run,
  input  logic                 step,
  input  logic                 seed_we,
  input  logic [3*OUT_W-1:0]   seed_data,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 tick_led
`ifdef PRNG_HEX_EN
  ,
  output logic [7*OUT_W/4-1:0] hex
`endif
);

  localparam int          DW       = 2 * OUT_W;
  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

  logic [31:0]      div_cnt;
  logic             tick;
  logic             evt;
  logic [DW-1:0]    data_state;
  logic [OUT_W-1:0] ctrl_state;
  logic [OUT_W-1:0] sel_word;
  logic             take_new;
  logic             drop_old;
  logic             ovr_set;

  // Divider: counts only while run is high, ticks on DIV-1 and wraps.
  assign tick = run && (div_cnt == DIV_LAST);

  always_ff @(posedge CLK) begin
    if (!EN) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= tick ? '0 : div_cnt + 32'd1;
    end
  end

  assign evt = (tick | step) & ~seed_we;

  prng_lfsr_core #(
    .W    (DW),
    .INIT (SEED_DATA)
  ) u_data_lfsr (
    .CLK      (CLK),
    .EN       (EN),
    .step     (evt),
    .load     (seed_we),
    .load_val (seed_data[DW-1:0]),
    .state    (data_state)
  );

  prng_lfsr_core #(
    .W    (OUT_W),
    .INIT (SEED_CTRL)
  ) u_ctrl_lfsr (
    .CLK      (CLK),
    .EN       (EN),
    .step     (evt),
    .load     (seed_we),
    .load_val (seed_data[3*OUT_W-1:DW]),
    .state    (ctrl_state)
  );

  // Each output bit picks one of its data bit pair using the pre-advance state.
  always_comb begin
    sel_word = '0;
    for (int j = 0; j < OUT_W; j++) begin
      sel_word[j] = ctrl_state[j] ? data_state[2*j+1] : data_state[2*j];
    end
  end

  // Handshake: a word transfers on a cycle where out_valid and out_ready are both high.
  // out_valid stays high until that transfer; out_data never changes while an
  // unconsumed word is held, and an event during that time is lost and flagged by overrun.
  assign take_new = evt && (!out_valid || out_ready);
  assign drop_old = out_valid && out_ready && !evt;
  assign ovr_set  = evt && out_valid && !out_ready;

  always_ff @(posedge CLK) begin
    if (!EN) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      tick_led  <= 1'b0;
    end else begin
      if (take_new) begin
        out_data  <= sel_word;
        out_valid <= 1'b1;
      end else if (drop_old) begin
        out_valid <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      if (evt) begin
        tick_led <= ~tick_led;
      end
    end
  end

`ifdef PRNG_HEX_EN
  localparam int NIB = OUT_W / 4;

  logic [7*NIB-1:0] hex_next;

  for (genvar n = 0; n < NIB; n++) begin : g_hex_dec
    assign hex_next[7*n +: 7] = seg_code(out_data[4*n +: 4]);
  end

  always_ff @(posedge CLK) begin
    if (!EN) begin
      hex <= {NIB{SEG_0}};
    end else begin
      hex <= hex_next;
    end
  end
`endif

endmodule

// File: tb/tb_prng_gen.sv
// Bench for prng_gen (OUT_W=8, DIV=4): directed scenarios plus random traffic against a cycle model.
module tb_prng_gen;

  localparam int OUT_W = 8;
  localparam int DIV   = 4;

  logic        CLK = 1'b0;
  logic        EN;
  logic        run;
  logic        step;
  logic        seed_we;
  logic [23:0] seed_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        ovr_clr;
  logic        tick_led;
`ifdef PRNG_HEX_EN
  logic [13:0] hex;
`endif

  prng_gen #(
    .OUT_W (OUT_W),
    .DIV   (DIV)
  ) dut (
    .CLK       (CLK),
    .EN        (EN),
    .run       (run),
    .step      (step),
    .seed_we   (seed_we),
    .seed_data (seed_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .tick_led  (tick_led)
`ifdef PRNG_HEX_EN
    ,
    .hex       (hex)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model state
  logic [15:0] m_data  = '0;
  logic [7:0]  m_ctrl  = '0;
  logic [7:0]  m_out   = '0;
  logic        m_valid = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_led   = 1'b0;
  int          m_runs  = 0;
  logic [13:0] m_hex   = '0;
  logic [7:0]  exp_q[$];

  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  int valid_cnt = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Next LFSR value from the listed tap positions: new LSB = XNOR of the tapped bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int w);
    int          taps[$];
    logic        fb;
    logic [63:0] mask;
    case (w)
      4:       taps = '{3, 2};
      8:       taps = '{7, 5, 4, 3};
      16:      taps = '{15, 14, 12, 3};
      default: taps = '{31, 21, 1, 0};
    endcase
    fb = 1'b1;
    foreach (taps[k]) fb = fb ^ s[taps[k]];
    mask = (64'd1 << w) - 64'd1;
    return 32'(((64'(s) << 1) | 64'(fb)) & mask);
  endfunction

  function automatic logic [7:0] pick(input logic [15:0] d, input logic [7:0] c);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = c[j] ? d[2*j+1] : d[2*j];
    return r;
  endfunction

  task automatic model_update();
    logic       tk;
    logic       ev;
    logic [7:0] sel;
    if (!EN) begin
      m_data = '0; m_ctrl = '0; m_out = '0; m_valid = 0; m_ovr = 0; m_led = 0;
      m_runs = 0; m_hex = {seg_tab[0], seg_tab[0]};
      exp_q.delete();
      return;
    end
    m_hex = {seg_tab[m_out[7:4]], seg_tab[m_out[3:0]]};
    tk = run && ((m_runs % DIV) == DIV - 1);
    if (run) m_runs++;
    ev  = (tk || step) && !seed_we;
    sel = pick(m_data, m_ctrl);
    if (ev && m_valid && !out_ready) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    if (ev && (!m_valid || out_ready)) begin
      m_out = sel; m_valid = 1; exp_q.push_back(sel);
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (ev) m_led = ~m_led;
    if (seed_we) begin
      m_data = (seed_data[15:0] == 16'hFFFF) ? 16'h0 : seed_data[15:0];
      m_ctrl = (seed_data[23:16] == 8'hFF) ? 8'h0 : seed_data[23:16];
    end else if (ev) begin
      m_data = 16'(lfsr_next(32'(m_data), 16));
      m_ctrl = 8'(lfsr_next(32'(m_ctrl), 8));
    end
  endtask

  // One clock: scoreboard the transfer, advance the model on the edge, compare after it.
  task automatic cycle();
    if (EN && m_valid && out_ready) begin
      words_seen++;
      if (exp_q.size() == 0) check("sb_size", 32'(exp_q.size()), 32'd1);
      else check("sb_word", 32'(out_data), 32'(exp_q.pop_front()));
    end
    @(posedge CLK);
    model_update();
    #1;
    check("out_data", 32'(out_data), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("tick_led", 32'(tick_led), 32'(m_led));
    check("data_lfsr", 32'(dut.u_data_lfsr.state), 32'(m_data));
    check("ctrl_lfsr", 32'(dut.u_ctrl_lfsr.state), 32'(m_ctrl));
`ifdef PRNG_HEX_EN
    check("hex", 32'(hex), 32'(m_hex));
`endif
  endtask

  task automatic set_idle();
    run = 0; step = 0; seed_we = 0; seed_data = '0; out_ready = 0; ovr_clr = 0;
  endtask

  initial begin
    set_idle();
    EN = 0;
    repeat (3) cycle();
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_tick_led", 32'(tick_led), 32'h0);

    // free-running from reset, one event every 4th cycle
    EN = 1; run = 1; out_ready = 1;
    repeat (4) cycle();
    check("first_word", 32'(out_data), 32'h00);
    check("first_valid", 32'(out_valid), 32'h1);
    check("first_data_lfsr", 32'(dut.u_data_lfsr.state), 32'h0001);
    check("first_ctrl_lfsr", 32'(dut.u_ctrl_lfsr.state), 32'h01);
    words_seen = 0;
    repeat (256 * 4) cycle();
    check("words_256", 32'(words_seen), 32'd256);

    // single-step with run low: pulses in cycles 3 and 10
    EN = 0; cycle();
    EN = 1; run = 0; out_ready = 1; valid_cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      step = (c == 3 || c == 10);
      cycle();
      if (out_valid) valid_cnt++;
    end
    step = 0;
    check("step_words", 32'(valid_cnt), 32'd2);
    check("step_led", 32'(tick_led), 32'h0);

    // overrun while the consumer stalls
    out_ready = 0;
    step = 1; cycle(); step = 0;
    repeat (2) cycle();
    step = 1; cycle(); step = 0;
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_hold_valid", 32'(out_valid), 32'h1);
    ovr_clr = 1; cycle(); ovr_clr = 0;
    check("ovr_clr", 32'(overrun), 32'h0);
    out_ready = 1; cycle();
    check("valid_drop", 32'(out_valid), 32'h0);

    // all-ones seed alongside step: load wins, both fields become zero
    seed_we = 1; step = 1; seed_data = 24'hFF_FFFF; cycle();
    seed_we = 0; step = 0;
    check("seed_no_evt", 32'(out_valid), 32'h0);
    check("seed_data_zero", 32'(dut.u_data_lfsr.state), 32'h0);
    check("seed_ctrl_zero", 32'(dut.u_ctrl_lfsr.state), 32'h0);
    step = 1; cycle(); step = 0;
    check("seed_word", 32'(out_data), 32'h00);

    // seed that selects 0x3A (ctrl 0, even data bits carry the word)
    seed_we = 1; seed_data = 24'h00_0544; cycle(); seed_we = 0;
    step = 1; cycle(); step = 0;
    check("word_3a", 32'(out_data), 32'h3A);
    cycle();
`ifdef PRNG_HEX_EN
    check("hex_3a", 32'(hex), {18'h0, 7'h30, 7'h08});
`endif

    // reset mid-run with a pending word
    run = 1; out_ready = 0;
    for (int c = 0; c < 8 && !out_valid; c++) cycle();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    EN = 0; cycle();
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    check("mid_rst_led", 32'(tick_led), 32'h0);
    check("mid_rst_div", dut.div_cnt, 32'h0);
    EN = 1; run = 1; out_ready = 1;
    repeat (3) cycle();
    check("restart_no_tick", 32'(out_valid), 32'h0);
    cycle();
    check("restart_tick", 32'(out_valid), 32'h1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      EN        = ($urandom_range(0, 199) != 0);
      run       = ($urandom_range(0, 3) != 0);
      step      = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      ovr_clr   = ($urandom_range(0, 15) == 0);
      seed_we   = ($urandom_range(0, 31) == 0);
      seed_data = 24'($urandom);
      if ($urandom_range(0, 3) == 0) seed_data[15:0] = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) seed_data[23:16] = 8'hFF;
      cycle();
    end
    set_idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
